// File: rtl/if_id_hazard_ctrl_if.sv
// Bundle of hazard inputs and pipeline control outputs for if_id_hazard_ctrl.
// The slave modport is the controller's view; the master modport is the
// view of whatever drives the hazard inputs and consumes the controls.
interface if_id_hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic             imem_ready;
    logic             dmem_busy;
    logic             redirect;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_hold;
    logic [1:0]       ctrl_state;
    logic [31:0]      stall_cycles;
    logic [31:0]      flush_cycles;

    modport slave (
        input  imem_ready, dmem_busy, redirect,
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
        output ctrl_state, stall_cycles, flush_cycles
    );

    modport master (
        output imem_ready, dmem_busy, redirect,
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
        input  ctrl_state, stall_cycles, flush_cycles
    );
endinterface

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID and PC sequencer: advances, freezes or flushes the fetch/decode
// boundary for load-use hazards, instruction-memory waits, data-memory
// freezes and EX-stage redirects (including a stale fetch in flight).
// Optional macro IF_ID_CTRL_STATS_EN builds saturating stall/flush counters;
// without it stall_cycles and flush_cycles are tied to zero.
module if_id_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    if_id_hazard_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IMISS = 2'd1,
        ST_DWAIT = 2'd2,
        ST_REDIR = 2'd3
    } state_t;

    state_t     state, state_next;
    state_t     saved, saved_next;
    state_t     eff_state;
    logic [2:0] flush_cnt, flush_cnt_next;
    logic       discard, discard_next;

    logic [REG_W-1:0] rs1, rs2, rd;
    logic             load_use;

    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold;

    assign rs1 = bus.id_rs1;
    assign rs2 = bus.id_rs2;
    assign rd  = bus.ex_rd;

    assign load_use = bus.ex_mem_read && (rd != '0) &&
                      ((bus.id_uses_rs1 && (rs1 == rd)) ||
                       (bus.id_uses_rs2 && (rs2 == rd)));

    // While frozen, decisions are taken as if still in the pre-freeze state
    assign eff_state = (state == ST_DWAIT) ? saved : state;

    // State, saved pre-freeze state, flush counter and stale-fetch flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            saved     <= ST_RUN;
            flush_cnt <= '0;
            discard   <= 1'b0;
        end else begin
            state     <= state_next;
            saved     <= saved_next;
            flush_cnt <= flush_cnt_next;
            discard   <= discard_next;
        end
    end

    // Prioritised next-state and control decode; reset forces a safe bubble
    always_comb begin
        pc_write       = 1'b0;
        if_id_write    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        ex_hold        = 1'b0;
        state_next     = state;
        saved_next     = saved;
        flush_cnt_next = flush_cnt;
        discard_next   = discard;

        if (bus.dmem_busy) begin
            ex_hold    = 1'b1;
            state_next = ST_DWAIT;
            if (state != ST_DWAIT) begin
                saved_next = state;
            end
        end else if (bus.redirect) begin
            pc_write       = 1'b1;
            if_id_write    = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            flush_cnt_next = 3'(FLUSH_CYCLES - 1);
            state_next     = (FLUSH_CYCLES > 1) ? ST_REDIR : ST_RUN;
            if (!bus.imem_ready) begin
                discard_next = 1'b1;
            end
        end else if (eff_state == ST_REDIR) begin
            pc_write       = bus.imem_ready;
            if_id_write    = 1'b1;
            if_id_flush    = 1'b1;
            flush_cnt_next = flush_cnt - 3'd1;
            state_next     = (flush_cnt <= 3'd1) ? ST_RUN : ST_REDIR;
        end else if (load_use) begin
            id_ex_bubble = 1'b1;
            state_next   = eff_state;
        end else if (!bus.imem_ready) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            state_next  = ST_IMISS;
        end else if (discard) begin
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            discard_next = 1'b0;
            state_next   = ST_RUN;
        end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            state_next  = ST_RUN;
        end

        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_hold      = 1'b0;
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.ex_hold      = ex_hold;
    assign bus.ctrl_state   = reset ? state : ST_RUN;

`ifdef IF_ID_CTRL_STATS_EN
    logic [31:0] stall_q, flush_q;

    // Saturating counts of PC-stalled cycles and IF/ID flush cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (if_id_flush && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_cycles = flush_q;
`else
    assign bus.stall_cycles = 32'd0;
    assign bus.flush_cycles = 32'd0;
`endif
endmodule
